// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the divider request arbiter.
// State encoding, id width and default sizing constants.
package div_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ZERO,
        CLEAR,
        BUSY,
        DONE
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 48;
    localparam int ID_W        = $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/div_request_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first request at/after ptr_i, wrapping.
// Ports: req_i (requests), ptr_i (priority start), gnt_o (one-hot), gnt_id_o, any_o.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               any_o
);

    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/div_request_arbiter.sv
// Shares one unsigned divider among NUM_REQ requesters (round-robin, one job in flight).
// Ports: req_* requester side, rsp_* result side, div_* divider side, clk/reset.
module div_request_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_n,
    input  logic [NUM_REQ*WIDTH-1:0]   req_d,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]           rsp_q,
    output logic [WIDTH-1:0]           rsp_r,
    output logic                       rsp_zero_err,
    output logic                       rsp_timeout,
    output logic                       div_reset,
    output logic                       div_valid,
    output logic [WIDTH-1:0]           div_n,
    output logic [WIDTH-1:0]           div_d,
    input  logic                       div_ready,
    input  logic [WIDTH-1:0]           div_q,
    input  logic [WIDTH-1:0]           div_r
);

    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   n_q, n_d, d_q, d_d;
    logic [WIDTH-1:0]   q_q, q_d, r_q, r_d;
    logic               z_q, z_d, t_q, t_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_id;
    logic               gnt_any;
    logic [WIDTH-1:0]   sel_n, sel_d;
    logic               idle;

    assign idle    = (state_q == IDLE) && !reset;
    assign arb_req = idle ? req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (IDW)
    ) u_rr (
        .req_i    (arb_req),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .any_o    (gnt_any)
    );

    // One-hot grant steers the winner's operands.
    always_comb begin
        sel_n = '0;
        sel_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_n = req_n[i*WIDTH +: WIDTH];
                sel_d = req_d[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            n_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            z_q     <= 1'b0;
            t_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            n_q     <= n_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            z_q     <= z_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        n_d     = n_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        z_d     = z_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    id_d  = gnt_id;
                    n_d   = sel_n;
                    d_d   = sel_d;
                    ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                    if (sel_d == '0) begin
                        // Result flags load now so they appear with rsp_valid.
                        q_d     = '0;
                        r_d     = '0;
                        z_d     = 1'b1;
                        t_d     = 1'b0;
                        state_d = ZERO;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            ZERO: state_d = IDLE;
            CLEAR: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // Ready takes priority over a coincident watchdog expiry.
                if (div_ready) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    z_d     = 1'b0;
                    t_d     = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    q_d     = '0;
                    r_d     = '0;
                    z_d     = 1'b0;
                    t_d     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready    = gnt;
    assign rsp_valid    = ((state_q == ZERO) || (state_q == DONE))
                        ? (NUM_REQ'(1) << id_q) : '0;
    assign rsp_q        = q_q;
    assign rsp_r        = r_q;
    assign rsp_zero_err = z_q;
    assign rsp_timeout  = t_q;
    assign div_reset    = reset || (state_q == CLEAR);
    assign div_valid    = (state_q == BUSY);
    assign div_n        = n_q;
    assign div_d        = d_q;

endmodule

// File: tb/tb_div_request_arbiter.sv
// Randomized and directed bench for div_request_arbiter with a behavioural divider.
// Expected grants/timing/results come from an abstract job-level model.
module tb_div_request_arbiter;
    import div_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 48;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_n = '0;
    logic [N*W-1:0]   req_d = '0;
    logic [N-1:0]     req_ready, rsp_valid;
    logic [W-1:0]     rsp_q, rsp_r, div_n, div_d;
    logic             rsp_zero_err, rsp_timeout;
    logic             div_reset, div_valid;
    logic             div_ready;
    logic [W-1:0]     div_q, div_r;

    div_request_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_n(req_n), .req_d(req_d),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_q(rsp_q), .rsp_r(rsp_r),
        .rsp_zero_err(rsp_zero_err), .rsp_timeout(rsp_timeout),
        .div_reset(div_reset), .div_valid(div_valid),
        .div_n(div_n), .div_d(div_d),
        .div_ready(div_ready), .div_q(div_q), .div_r(div_r)
    );

    always #5 clk = ~clk;

    // Behavioural divider: READY appears 'lat' valid cycles after its reset.
    int           lat = 32;
    int           mcnt = 0;
    logic         mrdy = 1'b0;
    logic [W-1:0] mq = '0, mr = '0;

    always @(posedge clk) begin
        if (div_reset) begin
            mcnt <= 0;
            mrdy <= 1'b0;
        end else if (div_valid && !mrdy) begin
            mcnt <= mcnt + 1;
            if (mcnt + 1 == lat) begin
                mrdy <= 1'b1;
                mq   <= div_n / div_d;
                mr   <= div_n % div_d;
            end
        end
    end

    assign div_ready = mrdy;
    assign div_q     = mq;
    assign div_r     = mr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Job-level reference model.
    logic [N-1:0] pend = '0;
    logic [W-1:0] pn [N];
    logic [W-1:0] pd [N];
    int           ptr_m = 0;
    bit           busy_m = 0;
    bit           zjob = 0;
    int           cyc = 0, acc = 0, rsp_cyc = 0, jid = 0;
    logic [W-1:0] jn, jd, eq, er;
    bit           ez, et;
    int           lat_sel = 32;
    bit           rnd_on = 0;

    int           gid_log [$];
    int           oid_log [$];
    logic [W-1:0] oq_log [$];
    logic [W-1:0] or_log [$];

    task automatic plan(input int g);
        acc  = cyc;
        jid  = g;
        jn   = pn[g];
        jd   = pd[g];
        zjob = (jd == 0);
        if (rnd_on) begin
            case ($urandom % 8)
                0: lat = TO - 1;
                1: lat = TO;
                2: lat = 1000;
                default: lat = int'($urandom_range(1, 40));
            endcase
        end else begin
            lat = lat_sel;
        end
        ez = 0; et = 0; eq = '0; er = '0;
        if (zjob) begin
            ez = 1;
            rsp_cyc = cyc + 1;
        end else if (lat >= TO) begin
            et = 1;
            rsp_cyc = cyc + 3 + (TO - 1);
        end else begin
            eq = jn / jd;
            er = jn % jd;
            rsp_cyc = cyc + 3 + lat;
        end
        busy_m = 1;
    endtask

    task automatic step();
        logic [N-1:0] exr, exv;
        bit edv, edr;
        int g, idx;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_n[i*W +: W]    = pn[i];
            req_d[i*W +: W]    = pd[i];
        end
        exr = '0;
        exv = '0;
        g   = -1;
        edr = busy_m && !zjob && (cyc == acc + 1);
        edv = busy_m && !zjob && (cyc >= acc + 2) && (cyc < rsp_cyc);
        if (busy_m && cyc == rsp_cyc) exv[jid] = 1'b1;
        if (!busy_m) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr_m + k) % N;
                if (g < 0 && pend[idx]) g = idx;
            end
            if (g >= 0) exr[g] = 1'b1;
        end
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exr));
        chk("rsp_valid", 64'(rsp_valid), 64'(exv));
        chk("div_valid", 64'(div_valid), 64'(edv));
        chk("div_reset", 64'(div_reset), 64'(edr));
        if (edv || edr) begin
            chk("div_n", 64'(div_n), 64'(jn));
            chk("div_d", 64'(div_d), 64'(jd));
        end
        if (exv != 0) begin
            chk("rsp_q", 64'(rsp_q), 64'(eq));
            chk("rsp_r", 64'(rsp_r), 64'(er));
            chk("zero_err", 64'(rsp_zero_err), 64'(ez));
            chk("timeout", 64'(rsp_timeout), 64'(et));
            busy_m = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i]) begin
                oid_log.push_back(i);
                oq_log.push_back(rsp_q);
                or_log.push_back(rsp_r);
            end
            if (req_ready[i]) gid_log.push_back(i);
        end
        if (g >= 0) begin
            plan(g);
            pend[g] = 1'b0;
            ptr_m   = (g + 1) % N;
        end
        if (rnd_on) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && i != g && ($urandom % 6) == 0) begin
                    pend[i] = 1'b1;
                    pn[i]   = ($urandom % 4 == 0) ? W'($urandom % 100) : W'($urandom);
                    case ($urandom % 8)
                        0:       pd[i] = '0;
                        1, 2:    pd[i] = W'($urandom_range(1, 15));
                        default: pd[i] = W'($urandom);
                    endcase
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(input int max);
        int s = 0;
        while ((busy_m || pend != 0) && s < max) begin
            step();
            s++;
        end
        if (busy_m || pend != 0) chk("drain_bound", 64'd1, 64'd0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_q", 64'(rsp_q), 64'd0);
        chk("rst_rsp_r", 64'(rsp_r), 64'd0);
        chk("rst_flags", 64'({rsp_zero_err, rsp_timeout}), 64'd0);
        chk("rst_div_valid", 64'(div_valid), 64'd0);
        chk("rst_div_nd", 64'({div_n, div_d}), 64'd0);
        chk("rst_div_reset", 64'(div_reset), 64'd1);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 chk_reset_outs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        busy_m = 0;
        ptr_m  = 0;
        cyc   += 3;
    endtask

    task automatic put(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
        pend[i] = 1'b1;
        pn[i]   = n;
        pd[i]   = d;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pn[i] = '0;
            pd[i] = '0;
        end
        #1 reset = 1'b1;
        #1 chk_reset_outs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1 and 2: basic divides
        put(0, 32'd50, 32'd2);
        run_idle(200);
        chk("t1_id", 64'(oid_log[oid_log.size()-1]), 64'd0);
        chk("t1_q", 64'(oq_log[oq_log.size()-1]), 64'd25);
        chk("t1_r", 64'(or_log[or_log.size()-1]), 64'd0);
        put(1, 32'h5555_5555, 32'hFFFF_FFFF);
        run_idle(200);
        chk("t2_id", 64'(oid_log[oid_log.size()-1]), 64'd1);
        chk("t2_q", 64'(oq_log[oq_log.size()-1]), 64'd0);
        chk("t2_r", 64'(or_log[or_log.size()-1]), 64'h5555_5555);

        // 3: all four pending after reset
        do_reset();
        gid_log.delete();
        oq_log.delete();
        or_log.delete();
        put(0, 32'd51, 32'd2);
        put(1, 32'd27, 32'd5);
        put(2, 32'hFFFF_FFFF, 32'h0000_BEEF);
        put(3, 32'h0001_3163, 32'h0000_0893);
        run_idle(600);
        chk("t3_ngrants", 64'(gid_log.size()), 64'd4);
        chk("t3_nrsp", 64'(oq_log.size()), 64'd4);
        if (gid_log.size() == 4 && oq_log.size() == 4) begin
            chk("t3_order", 64'({gid_log[0][3:0], gid_log[1][3:0],
                                 gid_log[2][3:0], gid_log[3][3:0]}), 64'h0123);
            chk("t3_q0", 64'(oq_log[0]), 64'd25);
            chk("t3_r0", 64'(or_log[0]), 64'd1);
            chk("t3_q1", 64'(oq_log[1]), 64'd5);
            chk("t3_r1", 64'(or_log[1]), 64'd2);
            chk("t3_q2", 64'(oq_log[2]), 64'h1573D);
            chk("t3_r2", 64'(or_log[2]), 64'h480C);
            chk("t3_q3", 64'(oq_log[3]), 64'h23);
            chk("t3_r3", 64'(or_log[3]), 64'h54A);
        end

        // 4: divide by zero short-circuit
        put(2, 32'd7, 32'd0);
        run_idle(50);

        // 5: stuck divider, then normal job; then ready on the last allowed cycle
        lat_sel = 1000;
        put(3, 32'd9, 32'd4);
        run_idle(200);
        lat_sel = 32;
        put(0, 32'd9, 32'd4);
        run_idle(200);
        lat_sel = TO - 1;
        put(1, 32'd100, 32'd7);
        run_idle(200);

        // 6: reset mid-BUSY drops the job and rewinds the pointer
        lat_sel = 1000;
        put(1, 32'd100, 32'd7);
        repeat (6) step();
        put(0, 32'd11, 32'd3);
        put(3, 32'd12, 32'd5);
        do_reset();
        lat_sel = 32;
        gid_log.delete();
        run_idle(400);
        chk("t6_first_grant", 64'(gid_log.size() > 0 ? gid_log[0] : -1), 64'd0);

        // randomized traffic
        rnd_on = 1;
        repeat (5000) step();
        rnd_on = 0;
        run_idle(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
